// File: rtl/aoi_test_pkg.sv
// Shared state type, sizes and the AOI golden function for four_input_aoi_tester.
package aoi_test_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCheck,
        StDone
    } state_e;

    localparam int unsigned NUM_VECTORS = 16;
    localparam int unsigned VEC_W       = 4;
    localparam int unsigned ERR_W       = 5;
    localparam int unsigned EFG_W       = 3;

    // Expected {E, F, G} for vec = {A, B, C, D}.
    function automatic logic [EFG_W-1:0] aoi_expect(input logic [VEC_W-1:0] vec);
        logic e;
        logic f;
        e = vec[3] & vec[2];
        f = vec[1] & vec[0];
        return {e, f, ~(e | f)};
    endfunction

endpackage

// File: rtl/aoi_ref_model.sv
// Combinational golden model of the 4-input AND-OR-INVERT gate.
module aoi_ref_model
    import aoi_test_pkg::*;
(
    input  logic [VEC_W-1:0] i_vec,
    output logic             o_e,
    output logic             o_f,
    output logic             o_g
);

    logic [EFG_W-1:0] w_expect;

    assign w_expect            = aoi_expect(i_vec);
    assign {o_e, o_f, o_g}     = w_expect;

endmodule

// File: rtl/four_input_aoi_tester.sv
// Exhaustive stimulus/check engine for a 4-input AOI gate: 16 vectors, settle, compare.
// Optional AOI_TESTER_STOP_ON_FAIL_EN: end the run at the first failing vector.
module four_input_aoi_tester
    import aoi_test_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = $clog2(SETTLE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             dut_a,
    output logic             dut_b,
    output logic             dut_c,
    output logic             dut_d,
    input  logic             dut_e,
    input  logic             dut_f,
    input  logic             dut_g,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [VEC_W-1:0] first_fail,
    output logic             fail_seen
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("four_input_aoi_tester: SETTLE_CYCLES must be in 1..255");
    end

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECTORS - 1);

    state_e             r_state;
    state_e             w_state_next;
    logic [VEC_W-1:0]   r_vec;
    logic [VEC_W-1:0]   w_vec_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [ERR_W-1:0]   r_err_count;
    logic [ERR_W-1:0]   w_err_next;
    logic [VEC_W-1:0]   r_first_fail;
    logic [VEC_W-1:0]   w_first_fail_next;
    logic               r_fail_seen;
    logic               w_fail_seen_next;
    logic               r_pass;
    logic               w_pass_next;

    logic               w_exp_e;
    logic               w_exp_f;
    logic               w_exp_g;
    logic               w_mismatch;
    logic               w_last_check;

    aoi_ref_model u_ref (
        .i_vec (r_vec),
        .o_e   (w_exp_e),
        .o_f   (w_exp_f),
        .o_g   (w_exp_g)
    );

    assign w_mismatch = ({dut_e, dut_f, dut_g} != {w_exp_e, w_exp_f, w_exp_g});

`ifdef AOI_TESTER_STOP_ON_FAIL_EN
    assign w_last_check = w_mismatch || (r_vec == LAST_VEC);
`else
    assign w_last_check = (r_vec == LAST_VEC);
`endif

    always_comb begin
        w_state_next      = r_state;
        w_vec_next        = r_vec;
        w_cnt_next        = r_cnt;
        w_err_next        = r_err_count;
        w_first_fail_next = r_first_fail;
        w_fail_seen_next  = r_fail_seen;
        w_pass_next       = r_pass;

        case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_next      = StSettle;
                    w_vec_next        = '0;
                    w_cnt_next        = CNT_LOAD;
                    w_err_next        = '0;
                    w_first_fail_next = '0;
                    w_fail_seen_next  = 1'b0;
                    w_pass_next       = 1'b0;
                end
            end
            StSettle: begin
                if (r_cnt == '0) begin
                    w_state_next = StCheck;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            StCheck: begin
                if (w_mismatch) begin
                    w_err_next = r_err_count + ERR_W'(1);
                    if (!r_fail_seen) begin
                        w_first_fail_next = r_vec;
                        w_fail_seen_next  = 1'b1;
                    end
                end
                if (w_last_check) begin
                    // pass reflects this vector's result as well
                    w_state_next = StDone;
                    w_pass_next  = (w_err_next == '0);
                end else begin
                    w_state_next = StSettle;
                    w_vec_next   = r_vec + VEC_W'(1);
                    w_cnt_next   = CNT_LOAD;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_vec        <= '0;
            r_cnt        <= '0;
            r_err_count  <= '0;
            r_first_fail <= '0;
            r_fail_seen  <= 1'b0;
            r_pass       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_vec        <= w_vec_next;
            r_cnt        <= w_cnt_next;
            r_err_count  <= w_err_next;
            r_first_fail <= w_first_fail_next;
            r_fail_seen  <= w_fail_seen_next;
            r_pass       <= w_pass_next;
        end
    end

    assign {dut_a, dut_b, dut_c, dut_d} = r_vec;
    assign busy       = (r_state != StIdle);
    assign done       = (r_state == StDone);
    assign pass       = r_pass;
    assign err_count  = r_err_count;
    assign first_fail = r_first_fail;
    assign fail_seen  = r_fail_seen;

endmodule

// File: doc/four_input_aoi_tester.md
Name: four_input_aoi_tester

Overview:
- Sequential stimulus-and-check engine for a 4-input AND-OR-INVERT device under test (DUT).
- The DUT computes E = A&B, F = C&D, G = ~(E|F).
- On a start pulse the block drives all 16 input vectors to the DUT, waits a settle time for each, and samples E/F/G against a reference model.
- It reports pass/fail, the error count and the first failing vector. It sits on the board-test side of the gate, facing the DUT's inputs and outputs.

Parameters:
- SETTLE_CYCLES, 4: cycles the stimulus is held before sampling; legal range 1..255; 0 triggers a simulation assertion.
- CNT_W, $clog2(SETTLE_CYCLES+1): settle counter width; derived, do not override.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  single-cycle run request; honoured only in IDLE.
- dut_a  output  1  DUT input A, equal to vec[3].
- dut_b  output  1  DUT input B, equal to vec[2].
- dut_c  output  1  DUT input C, equal to vec[1].
- dut_d  output  1  DUT input D, equal to vec[0].
- dut_e  input  1  DUT output E (A&B).
- dut_f  input  1  DUT output F (C&D).
- dut_g  input  1  DUT output G, the AOI result.
- busy  output  1  high from the cycle after an accepted start until DONE is left.
- done  output  1  one-cycle pulse at end of run.
- pass  output  1  valid after done; high iff err_count==0; held until next accepted start.
- err_count  output  5  number of failing vectors, 0..16.
- first_fail  output  4  vector index of the first mismatch; 0 if none.
- fail_seen  output  1  high once any mismatch has been recorded in the current run.

Behaviour:
- Reset (asynchronous, immediate, also mid-run):
  - State = IDLE; vec, settle counter, all dut_* outputs = 0.
  - busy, done, pass, err_count, first_fail, fail_seen = 0.
  - A run in progress is aborted with no done pulse.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE -> SETTLE on start=1:
  - vec=0, counter=SETTLE_CYCLES-1.
  - err_count, first_fail, fail_seen, pass cleared.
  - busy=1.
- SETTLE:
  - dut_* driven from the registered vec; the counter decrements each cycle.
  - At counter==0, go to CHECK. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- CHECK (one cycle):
  - Compare {dut_e,dut_f,dut_g} against the reference for vec.
  - On any bit mismatch: err_count += 1, once per vector regardless of how many bits differ. If fail_seen==0, set first_fail=vec and fail_seen=1.
  - If vec==15, go to DONE. Otherwise vec += 1, reload the counter, go to SETTLE.
- DONE (one cycle):
  - done=1; pass = (err_count==0) using the updated count; busy=1.
  - Next state is IDLE, with busy=0.
- Timing:
  - Per-vector cost is SETTLE_CYCLES+1 cycles.
  - done is high in the cycle following the 16*(SETTLE_CYCLES+1)-th rising edge after the edge that sampled start.
- Edge cases:
  - start while busy or in DONE is ignored, with no queueing.
  - start held high continuously re-arms only on return to IDLE.
  - vec never wraps. After vector 15 the block exits to DONE, and dut_* hold 4'b1111 until the next run or reset.
  - err_count saturates naturally at 16; 5 bits suffice.
  - DUT inputs are sampled only in CHECK. Glitches during SETTLE are not observed.

Optional Feature:
- Macro: AOI_TESTER_STOP_ON_FAIL_EN.
- Defined: the first mismatch in CHECK goes directly to DONE. err_count=1, pass=0, first_fail = the failing vector, and remaining vectors are skipped.
- Undefined: all 16 vectors always run and every mismatch is counted.

Decomposition:
- Package aoi_test_pkg holds:
  - state enum (IDLE/SETTLE/CHECK/DONE);
  - NUM_VECTORS=16, VEC_W=4, ERR_W=5;
  - function aoi_expect(vec) returning the expected {E,F,G}.
- One sub-module, aoi_ref_model: purely combinational, 4-bit vec in, expected E/F/G out. It is instantiated in the tester and reused by the bench as the golden model.
- The FSM, counter and result registers stay in four_input_aoi_tester.

Test Plan:
- Correct DUT model, SETTLE_CYCLES=4, start pulse -> busy high for 81 cycles; done pulses exactly 80 edges after the start edge; pass=1, err_count=0, fail_seen=0, dut_* sequence 0000..1111.
- DUT with G stuck-at-0 -> err_count=9 (vectors where A&B=0 and C&D=0), first_fail=0, pass=0.
- DUT with E stuck-at-1 -> err_count=12, first_fail=0. Then fix the model and rerun -> pass=1, err_count=0.
- AOI_TESTER_STOP_ON_FAIL_EN defined, G stuck-at-0, SETTLE_CYCLES=4 -> done 5 edges after start; err_count=1, first_fail=0.
- Assert rst during vector 7 SETTLE -> all outputs 0 immediately, no done pulse; a subsequent start runs cleanly to pass=1.
- start re-pulsed mid-run and during the DONE cycle -> ignored; run length unchanged; the next start after IDLE is accepted.
